divisor_seq: RTL and testbench
==============================

Name: divisor_seq

Overview:
- Burst sequencer around a programmable clock-enable divider.
- On a START handshake it latches a period and a pulse count, then issues exactly that many single-cycle TICK pulses, one every PERIODO+1 CE-qualified cycles. It then signals DONE and returns to idle.
- Sits between control logic and downstream blocks that need a bounded train of enable ticks (e.g. N baud ticks, N sample strobes).
- Contains its own divider counter and pulse counter; a single instance serves one client.

Parameters:
- BITS, 8, width of PERIODO and of the internal divider counter.
- NBITS, 8, width of N_PULSOS and CUENTA_PULSOS.

Ports:
- CLK  input  1  clock; all logic on rising edge.
- RST  input  1  synchronous reset, active-low (RST=0 resets on the next rising CLK edge).
- START  input  1  request to begin a burst; accepted only when READY=1.
- PERIODO  input  BITS  divider terminal count, sampled on START acceptance.
- N_PULSOS  input  NBITS  number of TICKs in the burst, sampled on START acceptance.
- CE  input  1  upstream clock enable; the divider advances only when CE=1.
- ABORT  input  1  terminates a running burst.
- READY  output  1  high in IDLE; START is accepted.
- BUSY  output  1  high in RUN.
- TICK  output  1  registered one-cycle divided pulse.
- DONE  output  1  registered one-cycle end-of-burst pulse.
- CUENTA_PULSOS  output  NBITS  TICKs issued in the current or last burst.

Behaviour:
- States: IDLE, RUN, FIN.
  - READY = (state==IDLE), decoded from state.
  - BUSY = (state==RUN), decoded from state.
- Reset (RST=0 at an edge):
  - state<=IDLE.
  - Divider count, pulse count, P_lat and N_lat <=0.
  - TICK<=0, DONE<=0.
  - READY=1 and BUSY=0 from that edge on.
- IDLE:
  - START=1 latches P_lat<=PERIODO and N_lat<=N_PULSOS, clears the divider count and CUENTA_PULSOS.
  - If N_PULSOS!=0, goes to RUN.
  - If N_PULSOS==0, goes to FIN with DONE=1 and TICK=0.
- RUN, cycle with CE=1:
  - If div_cnt==P_lat: div_cnt<=0, CUENTA_PULSOS<=CUENTA_PULSOS+1, TICK<=1 next cycle.
  - Otherwise div_cnt<=div_cnt+1.
  - If that tick is tick number N_lat, the state goes to FIN and DONE<=1 in the same cycle as the final TICK.
- RUN, cycle with CE=0: all counters hold; no TICK.
- TICK spacing:
  - First TICK appears 1 clock after the (P_lat+1)-th CE=1 cycle of RUN.
  - Subsequent TICKs are spaced P_lat+1 CE cycles apart.
  - P_lat=0 gives a TICK for every CE cycle.
- FIN:
  - Lasts exactly one cycle; READY=0, BUSY=0, DONE=1.
  - Then goes to IDLE. START in FIN is ignored.
- ABORT=1 in RUN:
  - Next state is IDLE; divider count and CUENTA_PULSOS cleared.
  - TICK=0 and DONE=0 on the following cycle.
  - Takes priority over a coincident terminal tick.
  - Ignored in IDLE and FIN.
- START while BUSY is ignored. PERIODO and N_PULSOS changes during a burst have no effect.
- CUENTA_PULSOS holds its final value (=N_lat) after DONE until the next accepted START, ABORT or reset.
- Counters use unsigned arithmetic.
  - div_cnt never exceeds P_lat.
  - The pulse counter cannot wrap: N_lat ≤ 2^NBITS−1 ends the burst first.
- Reset mid-burst behaves as above: no DONE, no TICK on the reset cycle.

Optional Feature:
- DIVISOR_SEQ_AUTORELOAD_EN defined:
  - READY is also high in FIN.
  - START=1 during FIN re-latches PERIODO and N_PULSOS and clears the counters.
  - Goes directly to RUN (or back to FIN with DONE=1 if N_PULSOS==0), giving back-to-back bursts with no idle cycle.
  - TICK spacing across the burst boundary is exactly P+1 CE cycles when CE is held high.
- Not defined: FIN always goes to IDLE, READY is low in FIN, and START in FIN is ignored.

Test Plan:
- Reset sequencing: RST=0 for 2 cycles then 1, no START -> READY=1, BUSY=0, TICK=0, DONE=0, CUENTA_PULSOS=0.
- Basic burst: CE=1 constant, START with PERIODO=3, N_PULSOS=4 -> 4 TICKs, 4 clocks apart, first TICK 4 clocks after RUN entry. DONE coincides with 4th TICK. CUENTA_PULSOS=4. READY returns 1 cycle after DONE.
- CE gating: PERIODO=1, N_PULSOS=2, CE high every 3rd cycle -> TICKs 6 clocks apart, none while CE=0.
- Boundary values: N_PULSOS=0 -> DONE one cycle after START, no TICK. PERIODO=0, N_PULSOS=3, CE=1 -> TICK on 3 consecutive cycles, DONE on the 3rd.
- ABORT: PERIODO=5, N_PULSOS=10, ABORT after 2nd TICK -> no further TICK, no DONE, IDLE and CUENTA_PULSOS=0 next cycle. START during RUN ignored.
- Autoreload (macro defined): START held high, PERIODO=2, N_PULSOS=2 -> continuous TICK every 3 cycles, DONE every 6 cycles, no READY gap in IDLE. Macro undefined: 1 idle cycle between bursts.

Source files
------------

// File: rtl/divisor_seq_if.sv
// Control/status bundle between a burst client and divisor_seq.
// Latency: none (wires only); backpressure: START is only honoured while READY=1.
// The master drives requests and enables; the slave returns status and ticks.
interface divisor_seq_if #(
    parameter int BITS  = 8,
    parameter int NBITS = 8
);
    logic             START;
    logic [BITS-1:0]  PERIODO;
    logic [NBITS-1:0] N_PULSOS;
    logic             CE;
    logic             ABORT;
    logic             READY;
    logic             BUSY;
    logic             TICK;
    logic             DONE;
    logic [NBITS-1:0] CUENTA_PULSOS;

    modport master (
        output START, PERIODO, N_PULSOS, CE, ABORT,
        input  READY, BUSY, TICK, DONE, CUENTA_PULSOS
    );

    modport slave (
        input  START, PERIODO, N_PULSOS, CE, ABORT,
        output READY, BUSY, TICK, DONE, CUENTA_PULSOS
    );
endinterface

// File: rtl/divisor_seq.sv
// Burst sequencer: N single-cycle TICKs, one every PERIODO+1 CE cycles, then DONE.
// Latency: TICK/DONE registered, 1 clk after the terminal CE cycle; START taken only when READY.
// Optional DIVISOR_SEQ_AUTORELOAD_EN: START accepted in FIN for gap-free back-to-back bursts.
module divisor_seq #(
    parameter int BITS  = 8,
    parameter int NBITS = 8
) (
    input  logic          CLK,
    input  logic          RST,
    divisor_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [BITS-1:0]  div_q, div_d;
    logic [BITS-1:0]  p_q, p_d;
    logic [NBITS-1:0] n_q, n_d;
    logic [NBITS-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;
    logic [NBITS-1:0] cnt_inc;

    assign cnt_inc = cnt_q + NBITS'(1);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            p_q     <= '0;
            n_q     <= '0;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            p_q     <= p_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        p_d     = p_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.START) begin
                    p_d   = bus.PERIODO;
                    n_d   = bus.N_PULSOS;
                    div_d = '0;
                    cnt_d = '0;
                    if (bus.N_PULSOS == '0) begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                // ABORT wins over a terminal tick in the same cycle.
                if (bus.ABORT) begin
                    state_d = S_IDLE;
                    div_d   = '0;
                    cnt_d   = '0;
                end else if (bus.CE) begin
                    if (div_q == p_q) begin
                        div_d  = '0;
                        cnt_d  = cnt_inc;
                        tick_d = 1'b1;
                        if (cnt_inc == n_q) begin
                            state_d = S_FIN;
                            done_d  = 1'b1;
                        end
                    end else begin
                        div_d = div_q + BITS'(1);
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
`ifdef DIVISOR_SEQ_AUTORELOAD_EN
                // The FIN cycle doubles as the first divider cycle of the next
                // burst, so tick spacing stays P+1 across the boundary.
                if (bus.START) begin
                    p_d   = bus.PERIODO;
                    n_d   = bus.N_PULSOS;
                    div_d = '0;
                    cnt_d = '0;
                    if (bus.N_PULSOS == '0) begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        if (bus.CE) begin
                            if (bus.PERIODO == '0) begin
                                tick_d = 1'b1;
                                cnt_d  = NBITS'(1);
                                if (bus.N_PULSOS == NBITS'(1)) begin
                                    state_d = S_FIN;
                                    done_d  = 1'b1;
                                end
                            end else begin
                                div_d = BITS'(1);
                            end
                        end
                    end
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
`ifdef DIVISOR_SEQ_AUTORELOAD_EN
        bus.READY = (state_q == S_IDLE) || (state_q == S_FIN);
`else
        bus.READY = (state_q == S_IDLE);
`endif
        bus.BUSY          = (state_q == S_RUN);
        bus.TICK          = tick_q;
        bus.DONE          = done_q;
        bus.CUENTA_PULSOS = cnt_q;
    end

endmodule

// File: tb/tb_divisor_seq.sv
// Directed plus random stimulus for divisor_seq against a countdown-based burst model.
module tb_divisor_seq;
    localparam int BITS  = 8;
    localparam int NBITS = 8;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    divisor_seq_if #(.BITS(BITS), .NBITS(NBITS)) bus ();
    divisor_seq #(.BITS(BITS), .NBITS(NBITS)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: phase 0 idle, 1 running, 2 finishing; 'left' counts
    // CE cycles still needed before the next tick.
    int phase = 0;
    int left  = 0;
    int mp    = 0;
    int mn    = 0;
    int mcnt  = 0;
    bit mtick = 0;
    bit mdone = 0;

    int cyc = 0;
    int tick_cnt = 0;
    int tick_at[$];
    int done_at[$];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic ce_tick();
        left--;
        if (left == 0) begin
            mtick = 1;
            mcnt++;
            left = mp + 1;
            if (mcnt == mn) begin
                phase = 2;
                mdone = 1;
            end
        end
    endtask

    task automatic begin_burst(bit fin_counts);
        mp   = int'(bus.PERIODO);
        mn   = int'(bus.N_PULSOS);
        mcnt = 0;
        if (mn == 0) begin
            phase = 2;
            mdone = 1;
        end else begin
            phase = 1;
            left  = mp + 1;
            if (fin_counts && bus.CE) ce_tick();
        end
    endtask

    task automatic model_edge();
        mtick = 0;
        mdone = 0;
        if (!RST) begin
            phase = 0;
            mcnt  = 0;
        end else begin
            case (phase)
                0: if (bus.START) begin_burst(0);
                1: begin
                    if (bus.ABORT) begin
                        phase = 0;
                        mcnt  = 0;
                    end else if (bus.CE) begin
                        ce_tick();
                    end
                end
                default: begin
                    phase = 0;
`ifdef DIVISOR_SEQ_AUTORELOAD_EN
                    if (bus.START) begin_burst(1);
`endif
                end
            endcase
        end
    endtask

    task automatic step();
        bit exp_ready;
        @(posedge CLK);
        model_edge();
        #1;
        cyc++;
`ifdef DIVISOR_SEQ_AUTORELOAD_EN
        exp_ready = (phase == 0) || (phase == 2);
`else
        exp_ready = (phase == 0);
`endif
        chk("ready", 32'(bus.READY), 32'(exp_ready));
        chk("busy",  32'(bus.BUSY),  32'(phase == 1));
        chk("tick",  32'(bus.TICK),  32'(mtick));
        chk("done",  32'(bus.DONE),  32'(mdone));
        chk("cuenta", 32'(bus.CUENTA_PULSOS), 32'(mcnt));
        if (bus.TICK === 1'b1) begin
            tick_cnt++;
            tick_at.push_back(cyc);
        end
        if (bus.DONE === 1'b1) done_at.push_back(cyc);
    endtask

    task automatic drive(bit s, int p, int n, bit ce, bit ab);
        bus.START    = s;
        bus.PERIODO  = BITS'(p);
        bus.N_PULSOS = NBITS'(n);
        bus.CE       = ce;
        bus.ABORT    = ab;
    endtask

    task automatic clear_log();
        tick_cnt = 0;
        tick_at.delete();
        done_at.delete();
    endtask

    task automatic run_until_done(string tag, int budget);
        int d0;
        d0 = done_at.size();
        for (int i = 0; i < budget && done_at.size() == d0; i++) step();
        chk({tag, "_done_seen"}, 32'(done_at.size() > d0), 32'd1);
    endtask

    initial begin
        int s;
        int gap;
        drive(0, 0, 0, 0, 0);
        RST = 1'b0;
        step();
        step();
        RST = 1'b1;
        step();
        chk("rst_ready", 32'(bus.READY), 32'd1);
        chk("rst_cuenta", 32'(bus.CUENTA_PULSOS), 32'd0);

        // Basic burst: P=3, N=4, CE high.
        clear_log();
        drive(1, 3, 4, 1, 0);
        step();
        s = cyc;
        drive(0, 0, 0, 1, 0);
        run_until_done("basic", 40);
        chk("basic_ticks", 32'(tick_cnt), 32'd4);
        if (tick_at.size() == 4) begin
            chk("basic_first", 32'(tick_at[0] - s), 32'd4);
            chk("basic_gap", 32'(tick_at[3] - tick_at[2]), 32'd4);
            chk("basic_done_on_last", 32'(done_at[0]), 32'(tick_at[3]));
        end
        chk("basic_cuenta", 32'(bus.CUENTA_PULSOS), 32'd4);
        step();
        chk("basic_ready_back", 32'(bus.READY), 32'd1);
        step();

        // CE gating: P=1, N=2, CE every third cycle.
        clear_log();
        drive(1, 1, 2, 0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 60 && done_at.size() == 0; i++) begin
            bus.CE = (cyc % 3 == 0);
            step();
        end
        chk("ce_ticks", 32'(tick_cnt), 32'd2);
        if (tick_at.size() == 2) chk("ce_gap", 32'(tick_at[1] - tick_at[0]), 32'd6);
        drive(0, 0, 0, 0, 0);
        step();
        step();

        // N=0: DONE right after START, no TICK.
        clear_log();
        drive(1, 7, 0, 1, 0);
        step();
        drive(0, 0, 0, 1, 0);
        chk("n0_done", 32'(bus.DONE), 32'd1);
        step();
        step();
        chk("n0_ticks", 32'(tick_cnt), 32'd0);

        // P=0, N=3: ticks on consecutive cycles.
        clear_log();
        drive(1, 0, 3, 1, 0);
        step();
        drive(0, 0, 0, 1, 0);
        run_until_done("p0", 20);
        chk("p0_ticks", 32'(tick_cnt), 32'd3);
        if (tick_at.size() == 3) chk("p0_span", 32'(tick_at[2] - tick_at[0]), 32'd2);
        step();
        step();

        // ABORT after the 2nd tick; START during RUN must be ignored.
        clear_log();
        drive(1, 5, 10, 1, 0);
        step();
        drive(1, 1, 1, 1, 0);
        for (int i = 0; i < 40 && tick_cnt < 2; i++) step();
        chk("abort_pre_ticks", 32'(tick_cnt), 32'd2);
        drive(0, 0, 0, 1, 1);
        step();
        drive(0, 0, 0, 1, 0);
        chk("abort_idle", 32'(bus.READY), 32'd1);
        chk("abort_cuenta", 32'(bus.CUENTA_PULSOS), 32'd0);
        for (int i = 0; i < 20; i++) step();
        chk("abort_no_more", 32'(tick_cnt), 32'd2);
        chk("abort_no_done", 32'(done_at.size()), 32'd0);

        // START held: back-to-back bursts P=2, N=2.
        clear_log();
        drive(1, 2, 2, 1, 0);
        for (int i = 0; i < 40; i++) step();
        drive(0, 0, 0, 0, 0);
        step();
        step();
        step();
`ifdef DIVISOR_SEQ_AUTORELOAD_EN
        gap = 6;
`else
        gap = 8;
`endif
        chk("b2b_dones", 32'(done_at.size() >= 3), 32'd1);
        if (done_at.size() >= 3) chk("b2b_period", 32'(done_at[2] - done_at[1]), 32'(gap));

        // Random traffic with occasional abort and reset.
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 3) == 0), $urandom_range(0, 3), $urandom_range(0, 4),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 29) == 0));
            RST = ($urandom_range(0, 149) != 0);
            step();
        end
        RST = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
